// File: rtl/eq_cfg_pkg.sv
// Shared types, constants and preset table for the equalizer gain write-port controller.
package eq_cfg_pkg;

    localparam int NUM_PRESETS = 4;
    localparam int BAND_W      = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        H_DATA  = 3'd1,
        H_WRITE = 3'd2,
        P_WRITE = 3'd3,
        P_DONE  = 3'd4
    } state_e;

    // 0 flat, 1 bass boost, 2 treble boost, 3 mute
    function automatic logic [7:0] preset_byte(input logic [1:0] sel, input logic [BAND_W-1:0] band);
        logic [7:0] b;
        b = 8'h20;
        case (sel)
            2'd1: case (band)
                4'd0, 4'd1: b = 8'h40;
                4'd2:       b = 8'h30;
                4'd3:       b = 8'h28;
                default:    b = 8'h20;
            endcase
            2'd2: case (band)
                4'd6:       b = 8'h28;
                4'd7:       b = 8'h30;
                4'd8, 4'd9: b = 8'h40;
                default:    b = 8'h20;
            endcase
            2'd3:    b = 8'h00;
            default: b = 8'h20;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] n;
        n = cur;
        if (cur < tgt) n = cur + 8'd1;
        else if (cur > tgt) n = cur - 8'd1;
        return n;
    endfunction

endpackage

// File: rtl/eq_cfg_host_rx.sv
// Host frame capture: latches the address byte, checks its range and runs the data-byte timeout.
module eq_cfg_host_rx
    import eq_cfg_pkg::*;
#(
    parameter int NUM_BANDS   = 10,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_addr_i,
    input  logic       count_i,
    input  logic [7:0] byte_i,
    output logic [7:0] addr_o,
    output logic       addr_ok_o,
    output logic       timeout_o
);

    logic [7:0]      addr_q, addr_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;

    // Counter saturates at the limit so a stalled host cannot wrap it back to zero.
    always_comb begin
        addr_d = addr_q;
        tcnt_d = tcnt_q;
        if (cap_addr_i) begin
            addr_d = byte_i;
            tcnt_d = '0;
        end else if (count_i && (tcnt_q < TO_W'(TIMEOUT_CYC))) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            tcnt_q <= '0;
        end else begin
            addr_q <= addr_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign addr_o    = addr_q;
    assign addr_ok_o = (addr_q < 8'(NUM_BANDS));
    assign timeout_o = (tcnt_q == TO_W'(TIMEOUT_CYC));

endmodule

// File: rtl/eq_gain_cfg_ctrl.sv
// Arbitrates the gain register map write port between host frames and the preset loader.
// Build option GAIN_RAMP_EN: host writes ramp by +/-1 per cycle using per-band shadow copies.
module eq_gain_cfg_ctrl
    import eq_cfg_pkg::*;
#(
    parameter int NUM_BANDS   = 10,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_valid,
    input  logic [7:0] host_byte,
    output logic       host_ready,
    input  logic       preset_start,
    input  logic [1:0] preset_sel,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    // Handshake: a host byte moves only on a cycle where host_valid && host_ready;
    // host_valid may wait for ready, and ready never depends on host_valid.
    state_e            state_q;
    logic              pend_q;
    logic [1:0]        sel_q;
    logic [BAND_W-1:0] band_q;
    logic              reg_we_q, busy_q, done_q, err_q;
    logic [7:0]        reg_addr_q, reg_data_q;
    logic              xfer, addr_ok, timeout;
    logic [7:0]        haddr;
    logic [1:0]        sel_eff;
    logic [BAND_W-1:0] band_nx;

`ifdef GAIN_RAMP_EN
    logic [7:0] shadow_q [NUM_BANDS];
    logic [7:0] target_q;
`endif

    assign host_ready = rst && (((state_q == IDLE) && !pend_q && !preset_start) || (state_q == H_DATA));
    assign xfer       = host_valid && host_ready;
    assign sel_eff    = preset_start ? preset_sel : sel_q;
    assign band_nx    = BAND_W'(band_q + 1'b1);

    eq_cfg_host_rx #(
        .NUM_BANDS  (NUM_BANDS),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_host_rx (
        .clk       (clk),
        .rst       (rst),
        .cap_addr_i(xfer && (state_q == IDLE)),
        .count_i   (!xfer && (state_q == H_DATA)),
        .byte_i    (host_byte),
        .addr_o    (haddr),
        .addr_ok_o (addr_ok),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            sel_q      <= '0;
            band_q     <= '0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef GAIN_RAMP_EN
            target_q   <= '0;
            for (int i = 0; i < NUM_BANDS; i++) shadow_q[i] <= '0;
`endif
        end else begin
            reg_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            if (preset_start) begin
                sel_q <= preset_sel;
                if (state_q != P_WRITE) pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pend_q || preset_start) begin
                        state_q    <= P_WRITE;
                        pend_q     <= 1'b0;
                        band_q     <= '0;
                        reg_we_q   <= 1'b1;
                        reg_addr_q <= 8'd0;
                        reg_data_q <= preset_byte(sel_eff, '0);
                        busy_q     <= 1'b1;
`ifdef GAIN_RAMP_EN
                        shadow_q[0] <= preset_byte(sel_eff, '0);
`endif
                    end else if (xfer) begin
                        state_q <= H_DATA;
                        busy_q  <= 1'b1;
                    end
                end
                H_DATA: begin
                    if (xfer && addr_ok) begin
                        state_q    <= H_WRITE;
                        reg_we_q   <= 1'b1;
                        reg_addr_q <= haddr;
`ifdef GAIN_RAMP_EN
                        target_q   <= host_byte;
                        reg_data_q <= ramp_step(shadow_q[haddr[BAND_W-1:0]], host_byte);
                        shadow_q[haddr[BAND_W-1:0]] <= ramp_step(shadow_q[haddr[BAND_W-1:0]], host_byte);
`else
                        reg_data_q <= host_byte;
`endif
                    end else if (xfer || timeout) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                H_WRITE: begin
`ifdef GAIN_RAMP_EN
                    if (reg_data_q != target_q) begin
                        reg_we_q   <= 1'b1;
                        reg_data_q <= ramp_step(reg_data_q, target_q);
                        shadow_q[reg_addr_q[BAND_W-1:0]] <= ramp_step(reg_data_q, target_q);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                P_WRITE: begin
                    if (band_q == BAND_W'(NUM_BANDS - 1)) begin
                        state_q <= P_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        band_q     <= band_nx;
                        reg_we_q   <= 1'b1;
                        reg_addr_q <= 8'(band_nx);
                        reg_data_q <= preset_byte(sel_eff, band_nx);
`ifdef GAIN_RAMP_EN
                        shadow_q[band_nx] <= preset_byte(sel_eff, band_nx);
`endif
                    end
                end
                P_DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_eq_gain_cfg_ctrl.sv
// Scoreboard bench for eq_gain_cfg_ctrl: expected writes/err/done events are queued and popped by a monitor.
module tb_eq_gain_cfg_ctrl;

  logic       clk;
  logic       rst;
  logic       host_valid;
  logic [7:0] host_byte;
  logic       host_ready;
  logic       preset_start;
  logic [1:0] preset_sel;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_dbg;

  // event word: {kind[1:0], addr[7:0], data[7:0]}; kind 0=write 1=err 2=done
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] preset_tab [4][10];

  eq_gain_cfg_ctrl dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_byte(host_byte), .host_ready(host_ready),
    .preset_start(preset_start), .preset_sel(preset_sel),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // reference model: frame and preset expectations
  task automatic expect_frame(input logic [7:0] a, input logic [7:0] d);
    if (a < 8'd10) exp_q.push_back({2'd0, a, d});
    else exp_q.push_back({2'd1, 16'h0});
  endtask

  task automatic expect_preset(input int sel);
    for (int b = 0; b < 10; b++) exp_q.push_back({2'd0, 8'(b), preset_tab[sel][b]});
    exp_q.push_back({2'd2, 16'h0});
  endtask

  // monitor
  always @(negedge clk) begin
    logic [17:0] act, e;
    if (rst && (reg_we || err || done)) begin
      act = reg_we ? {2'd0, reg_addr, reg_data} : (err ? {2'd1, 16'h0} : {2'd2, 16'h0});
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event got=%h exp=none", act);
      end else begin
        e = exp_q.pop_front();
        check("event", 32'(act), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    host_valid = 1'b1;
    host_byte  = b;
    #1;
    while (!host_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!host_ready) check("send_byte_wait", 32'(n), 32'(0));
    @(posedge clk);
    #1 host_valid = 1'b0;
  endtask

  task automatic pulse_preset(input logic [1:0] sel);
    @(negedge clk);
    preset_start = 1'b1;
    preset_sel   = sel;
    @(posedge clk);
    #1 preset_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    int cnt;
    logic [7:0] a, d;
    preset_tab[0] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    preset_tab[1] = '{8'h40, 8'h40, 8'h30, 8'h28, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    preset_tab[2] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h28, 8'h30, 8'h40, 8'h40};
    preset_tab[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b0;
    host_valid = 1'b0;
    host_byte = 8'h00;
    preset_start = 1'b0;
    preset_sel = 2'd0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({reg_we, reg_addr, reg_data, host_ready, busy, done, err}), 32'(0));
    rst = 1'b1;
    #1 check("ready_after_reset", 32'(host_ready), 32'(1));

    // basic frame and write latency
    expect_frame(8'h03, 8'h55);
    send_byte(8'h03);
    send_byte(8'h55);
    check("write_latency", 32'({reg_we, reg_addr, reg_data}), 32'({1'b1, 8'h03, 8'h55}));
    check("no_err_on_write", 32'(err), 32'(0));

    // address range boundaries
    expect_frame(8'h0A, 8'h11); send_byte(8'h0A); send_byte(8'h11);
    expect_frame(8'h09, 8'hA5); send_byte(8'h09); send_byte(8'hA5);
    expect_frame(8'hFF, 8'h01); send_byte(8'hFF); send_byte(8'h01);
    expect_frame(8'h00, 8'h7E); send_byte(8'h00); send_byte(8'h7E);
    wait_idle();

    // preset bass, busy spans 10 writes plus done
    expect_preset(1);
    pulse_preset(2'd1);
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("preset_busy_cycles", 32'(cnt), 32'(11));

    // preset and host address byte on the same cycle
    wait_idle();
    expect_preset(2);
    expect_frame(8'h04, 8'hC3);
    @(negedge clk);
    preset_start = 1'b1;
    preset_sel = 2'd2;
    host_valid = 1'b1;
    host_byte = 8'h04;
    #1 check("collision_ready_low", 32'(host_ready), 32'(0));
    @(posedge clk);
    #1 preset_start = 1'b0;
    send_byte(8'h04);
    send_byte(8'hC3);

    // timeout then a normal frame to the same band
    wait_idle();
    exp_q.push_back({2'd1, 16'h0});
    send_byte(8'h02);
    repeat (300) @(negedge clk);
    expect_frame(8'h02, 8'h7F); send_byte(8'h02); send_byte(8'h7F);

    // slow but in-time data byte
    expect_frame(8'h05, 8'h66);
    send_byte(8'h05);
    repeat (200) @(negedge clk);
    send_byte(8'h66);

    // preset requested mid-frame runs after the frame
    wait_idle();
    expect_frame(8'h06, 8'h33);
    expect_preset(3);
    send_byte(8'h06);
    pulse_preset(2'd3);
    send_byte(8'h33);
    wait_idle();

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cnt = $urandom_range(0, 3);
        expect_preset(cnt);
        pulse_preset(2'(cnt));
        wait_idle();
      end else begin
        a = 8'($urandom_range(0, 15));
        d = 8'($urandom_range(0, 255));
        expect_frame(a, d);
        send_byte(a);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(d);
      end
    end
    wait_idle();

    // reset during band 4 of a preset
    expect_preset(0);
    pulse_preset(2'd0);
    cnt = 0;
    @(negedge clk);
    while (!(reg_we && reg_addr == 8'd4) && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("reached_band4", 32'({reg_we, reg_addr}), 32'({1'b1, 8'd4}));
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", 32'({reg_we, reg_addr, reg_data, host_ready, busy, done, err}), 32'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_after_abort", 32'(busy), 32'(0));

    // drain
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eq_gain_cfg_ctrl.md
Name: eq_gain_cfg_ctrl

Overview:
Write-port controller for the equalizer gain register map (10 bands, 8-bit gain codes converted to Q5.8 inside the map). Arbitrates the map's single write port (we/addr/data_in) between a host byte-stream requester and an internal preset loader. The preset loader sequences all 10 band writes from a fixed preset table. Sits between the host interface/bridge and the register map.

Parameters:
NUM_BANDS, 10, number of gain registers; valid addresses 0..NUM_BANDS-1
TIMEOUT_CYC, 255, max cycles allowed between the address byte and the data byte of a host frame
TO_W, 8, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
host_valid  in  1  host byte valid
host_byte  in  8  host byte; frame = address byte, then data byte
host_ready  out  1  controller accepts host_byte this cycle
preset_start  in  1  single-cycle request to load a preset
preset_sel  in  2  preset index, sampled on the cycle preset_start is high
reg_we  out  1  write strobe to the register map
reg_addr  out  8  write address to the register map
reg_data  out  8  write data byte to the register map
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse after the last preset write
err  out  1  1-cycle pulse on invalid address or frame timeout

Behaviour:
- Reset: reg_we=0, reg_addr=0, reg_data=0, host_ready=0, busy=0, done=0, err=0. FSM goes to IDLE. Pending preset, latched address, band counter and timeout counter all clear. Reset asserted mid-frame or mid-preset aborts the operation; no further writes are issued.
- All outputs are registered. host_ready is the only combinational output: it is 1 in IDLE when no preset is pending and preset_start=0, and 1 in H_DATA. It is 0 in all other cases.
- A byte transfer occurs when host_valid && host_ready.
- preset_start sets pend=1 and latches sel. A second preset_start while pend=1 or while in P_WRITE overwrites sel only. pend clears on entry to P_WRITE.
- FSM states:
  - IDLE:
    - If pend or preset_start is high, go to P_WRITE. Preset wins over a simultaneous host byte; that host byte is not accepted.
    - Else, on a host transfer, latch addr=host_byte, clear the timeout counter, go to H_DATA.
  - H_DATA:
    - On transfer: if addr<NUM_BANDS, go to H_WRITE; else pulse err next cycle and return to IDLE with no write.
    - If there is no transfer and the timeout counter reaches TIMEOUT_CYC, pulse err and return to IDLE.
    - A preset request arriving here is held pending until the frame completes.
  - H_WRITE: reg_we=1, reg_addr=addr, reg_data=the data byte, for exactly one cycle. Then go to IDLE.
    - Latency: reg_we is high the cycle after the data-byte transfer.
  - P_WRITE: band counter runs 0..NUM_BANDS-1 on consecutive cycles.
    - reg_we=1, reg_addr=counter, reg_data=PRESET[sel][counter].
    - After the last band, go to P_DONE.
  - P_DONE: done=1 for one cycle, then go to IDLE.
- reg_we is 1 only in H_WRITE and P_WRITE, and never for more than one write per cycle.
- Boundary cases:
  - addr=NUM_BANDS-1 is valid.
  - addr=NUM_BANDS through 255 is an error.
  - Timeout counter saturates and does not wrap.
  - Back-to-back frames are allowed with one idle cycle (H_WRITE) between them.

Optional Feature:
GAIN_RAMP_EN
- Defined: host writes ramp rather than jump. The controller keeps a shadow copy of each band (reset 0). In H_WRITE it steps the band toward the target by ±1 per write, issuing one reg_we every cycle until the target is reached, then returns to IDLE. busy stays high throughout. Preset loads also update the shadow copies.
- Undefined: single-write jump as described above, and no shadow storage.

Decomposition:
- Package eq_cfg_pkg:
  - State enum (IDLE, H_DATA, H_WRITE, P_WRITE, P_DONE).
  - NUM_PRESETS=4.
  - Preset table function preset_byte(sel, band):
    - 0 flat: all 8'h20.
    - 1 bass: 40,40,30,28,20,20,20,20,20,20.
    - 2 treble: 20,20,20,20,20,20,28,30,40,40 (hex).
    - 3 mute: all 00.
- One natural sub-module: eq_cfg_host_rx (frame capture, timeout counter, address check). The FSM and preset sequencer stay in the top module.

Test Plan:
- Host sends 0x03 then 0x55 -> exactly one reg_we, one cycle after the 2nd byte, with addr=3, data=0x55. err=0.
- Host sends 0x0A then 0x11 -> no reg_we; err pulses once; FSM returns to IDLE.
- preset_start with preset_sel=1 -> 10 consecutive reg_we with addr 0..9 and data 40,40,30,28,20,…,20. done follows on the next cycle. busy is high for 11 cycles.
- preset_start on the same cycle as a host address byte -> host_ready=0 that cycle and the preset runs first. The host byte is accepted after done.
- Address byte 0x02, then nothing for 255 cycles -> err pulse and no write. A following frame (0x02, 0x7F) writes normally.
- rst low during preset write of band 4 -> all outputs 0 immediately. After release, no further writes and busy=0.
